// File: rtl/izhikevich_array.sv
`default_nettype none
// ============================================================================
// Module : izhikevich_array
// Time-multiplexed Izhikevich neurons: one datapath advances every neuron per
// step. Define IZH_REFRACTORY_EN to add per-neuron refractory counters.
// Rev    : 1.0
// ============================================================================
module izhikevich_array #(
  parameter int N = 18,
  parameter int FRAC = 16,
  parameter int NUM_NEURONS = 4,
  parameter int DT_SHIFT = 4,
  parameter logic signed [N-1:0] V_INIT = 18'sh3_4CCD,
  parameter logic signed [N-1:0] U_INIT = 18'sh3_CCCD,
  parameter logic signed [N-1:0] V_TH = 18'sh0_4CCC,
  parameter logic signed [N-1:0] C14 = 18'sh1_6666,
`ifdef IZH_REFRACTORY_EN
  parameter int REFRACT_STEPS = 2,
`endif
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic          busy,
  output logic          done,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_addr,
  input  logic [2:0]    cfg_sel,
  input  logic [N-1:0]  cfg_data,
  output logic          spike_valid,
  output logic [AW-1:0] spike_id,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_v,
  output logic [N-1:0]  rd_u
);

  localparam int SW = N + 4;
  localparam int PW = 2 * N;
  localparam logic [AW:0] NUM_W = (AW + 1)'(NUM_NEURONS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic signed [N-1:0] sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = {{(PW - N + 1){1'b0}}, {(N - 1){1'b1}}};
    lo = {{(PW - N + 1){1'b1}}, {(N - 1){1'b0}}};
    if (x > hi)      sat = hi[N-1:0];
    else if (x < lo) sat = lo[N-1:0];
    else             sat = x[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] sat_sum(input logic signed [SW-1:0] s);
    sat_sum = sat(PW'(s));
  endfunction

  // Full-width product, floor-shift back to the Q format, then clamp.
  function automatic logic signed [N-1:0] fx_mul(input logic signed [N-1:0] x,
                                                 input logic signed [N-1:0] y);
    logic signed [PW-1:0] p;
    p = PW'(x) * PW'(y);
    fx_mul = sat(p >>> FRAC);
  endfunction

  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  logic signed [N-1:0] v_q   [NUM_NEURONS];
  logic signed [N-1:0] v_d   [NUM_NEURONS];
  logic signed [N-1:0] u_q   [NUM_NEURONS];
  logic signed [N-1:0] u_d   [NUM_NEURONS];
  logic signed [N-1:0] a_q   [NUM_NEURONS];
  logic signed [N-1:0] a_d   [NUM_NEURONS];
  logic signed [N-1:0] b_q   [NUM_NEURONS];
  logic signed [N-1:0] b_d   [NUM_NEURONS];
  logic signed [N-1:0] c_q   [NUM_NEURONS];
  logic signed [N-1:0] c_d   [NUM_NEURONS];
  logic signed [N-1:0] d_q   [NUM_NEURONS];
  logic signed [N-1:0] d_d   [NUM_NEURONS];
  logic signed [N-1:0] cur_q [NUM_NEURONS];
  logic signed [N-1:0] cur_d [NUM_NEURONS];
  logic signed [N-1:0] vth_q [NUM_NEURONS];
  logic signed [N-1:0] vth_d [NUM_NEURONS];

  logic          spike_valid_q, spike_valid_d;
  logic [AW-1:0] spike_id_q, spike_id_d;
  logic [N-1:0]  rd_v_q, rd_v_d;
  logic [N-1:0]  rd_u_q, rd_u_d;

`ifdef IZH_REFRACTORY_EN
  localparam int RW = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
  logic [RW-1:0] ref_q [NUM_NEURONS];
  logic [RW-1:0] ref_d [NUM_NEURONS];
  logic [RW-1:0] ref_cur;
  logic [RW-1:0] ref_new;
`endif

  logic signed [N-1:0]  v_old, u_old, a_cur, b_cur, c_cur, d_cur, i_cur, vth_cur;
  logic signed [N-1:0]  vv, dv, v_euler, bv, bv_diff, du, u_euler, u_spike;
  logic signed [SW-1:0] v_sum;
  logic signed [N-1:0]  v_new, u_new;
  logic                 spike_cond, spike_now;

  // Shared datapath: operates on the neuron selected by idx_q.
  always_comb begin
    v_old   = v_q[idx_q];
    u_old   = u_q[idx_q];
    a_cur   = a_q[idx_q];
    b_cur   = b_q[idx_q];
    c_cur   = c_q[idx_q];
    d_cur   = d_q[idx_q];
    i_cur   = cur_q[idx_q];
    vth_cur = vth_q[idx_q];

    spike_cond = (v_old > vth_cur);

    vv      = fx_mul(v_old, v_old);
    v_sum   = (SW'(vv) <<< 2) + (SW'(v_old) <<< 2) + SW'(v_old)
            + SW'(C14) - SW'(u_old) + SW'(i_cur);
    dv      = sat_sum(v_sum) >>> DT_SHIFT;
    v_euler = sat_sum(SW'(v_old) + SW'(dv));

    bv      = fx_mul(b_cur, v_old);
    bv_diff = sat_sum(SW'(bv) - SW'(u_old));
    du      = fx_mul(a_cur, bv_diff) >>> DT_SHIFT;
    u_euler = sat_sum(SW'(u_old) + SW'(du));
    u_spike = sat_sum(SW'(u_old) + SW'(d_cur));

    v_new     = v_euler;
    u_new     = u_euler;
    spike_now = 1'b0;
    if (spike_cond) begin
      v_new     = c_cur;
      u_new     = u_spike;
      spike_now = 1'b1;
    end
`ifdef IZH_REFRACTORY_EN
    ref_cur = ref_q[idx_q];
    ref_new = ref_cur;
    if (ref_cur != '0) begin
      v_new     = c_cur;
      u_new     = u_old;
      spike_now = 1'b0;
      ref_new   = ref_cur - RW'(1);
    end else if (spike_cond) begin
      ref_new = RW'(REFRACT_STEPS);
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spike_valid_d = 1'b0;
    spike_id_d    = spike_id_q;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      v_d[k]   = v_q[k];
      u_d[k]   = u_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      c_d[k]   = c_q[k];
      d_d[k]   = d_q[k];
      cur_d[k] = cur_q[k];
      vth_d[k] = vth_q[k];
`ifdef IZH_REFRACTORY_EN
      ref_d[k] = ref_q[k];
`endif
    end

    case (state_q)
      S_IDLE: begin
        // A pending config write takes priority; the step is dropped.
        if (cfg_valid) begin
          if ({1'b0, cfg_addr} < NUM_W) begin
            case (cfg_sel)
              3'd0:    a_d[cfg_addr]   = cfg_data;
              3'd1:    b_d[cfg_addr]   = cfg_data;
              3'd2:    c_d[cfg_addr]   = cfg_data;
              3'd3:    d_d[cfg_addr]   = cfg_data;
              3'd4:    cur_d[cfg_addr] = cfg_data;
              3'd5:    v_d[cfg_addr]   = cfg_data;
              3'd6:    u_d[cfg_addr]   = cfg_data;
              default: vth_d[cfg_addr] = cfg_data;
            endcase
          end
        end else if (step) begin
          state_d = S_RUN;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        v_d[idx_q] = v_new;
        u_d[idx_q] = u_new;
`ifdef IZH_REFRACTORY_EN
        ref_d[idx_q] = ref_new;
`endif
        spike_valid_d = spike_now;
        if (spike_now) spike_id_d = idx_q;
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + AW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_v_d = '0;
    rd_u_d = '0;
    if ({1'b0, rd_addr} < NUM_W) begin
      rd_v_d = v_d[rd_addr];
      rd_u_d = u_d[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      rd_v_q        <= '0;
      rd_u_q        <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_q[k]   <= V_INIT;
        u_q[k]   <= U_INIT;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= '0;
        d_q[k]   <= '0;
        cur_q[k] <= '0;
        vth_q[k] <= V_TH;
`ifdef IZH_REFRACTORY_EN
        ref_q[k] <= '0;
`endif
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_valid_q <= spike_valid_d;
      spike_id_q    <= spike_id_d;
      rd_v_q        <= rd_v_d;
      rd_u_q        <= rd_u_d;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_q[k]   <= v_d[k];
        u_q[k]   <= u_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        c_q[k]   <= c_d[k];
        d_q[k]   <= d_d[k];
        cur_q[k] <= cur_d[k];
        vth_q[k] <= vth_d[k];
`ifdef IZH_REFRACTORY_EN
        ref_q[k] <= ref_d[k];
`endif
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign cfg_ready   = ~busy;
  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;
  assign rd_v        = rd_v_q;
  assign rd_u        = rd_u_q;

endmodule
`default_nettype wire
